// File: rtl/alu_serial_ctrl_if.sv
// ============================================================================
// Module   : alu_serial_ctrl_if
// Purpose  : Request/result bundle between a client and the bit-serial ALU
//            sequencer. The client drives start/op/operands, and the sequencer
//            returns ready/done, the result and the flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             err;

  modport master (
    output start, op, opA, opB,
    input  ready, done, result, zero, carry, overflow, err
  );

  modport slave (
    input  start, op, opA, opB,
    output ready, done, result, zero, carry, overflow, err
  );
endinterface

`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
// ============================================================================
// Module   : alu_serial_ctrl
// Purpose  : Bit-serial sequencer that turns one combinational 1-bit ALU slice
//            into a full-width ALU. It runs LSB first and feeds the carry back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_serial_ctrl_if.slave bus,
  output logic            aluA,
  output logic            aluB,
  output logic            aluCin,
  output logic [1:0]      aluSel,
  output logic            aluBinvert,
  output logic            aluLess,
  input  wire logic       aluDataOut,
  input  wire logic       aluCout
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_SLT_FIX = 3'd2;
  localparam logic [2:0] ST_ILLEGAL = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             sign_q;
  logic             zero_q;
  logic             carry_out_q;
  logic             ovf_q;
  logic             err_q;

  logic             idle_like;
  logic             accept;
  logic             op_legal;
  logic             last_bit;
  logic             is_arith;
  logic             is_slt;
  logic [WIDTH-1:0] result_shift;

  assign idle_like    = (state == ST_IDLE) || (state == ST_DONE);
  assign accept       = bus.start && idle_like;
  assign op_legal     = bus.op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
  assign last_bit     = (cnt == CNT_W'(WIDTH - 1));
  // ADD, SUB and SLT all have op[1] set. AND and OR do not.
  assign is_arith     = op_q[1];
  assign is_slt       = (op_q == OP_SLT);
  assign result_shift = {aluDataOut, result_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nxt = op_legal ? ST_RUN : ST_ILLEGAL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          state_nxt = is_slt ? ST_SLT_FIX : ST_DONE;
        end
      end
      ST_SLT_FIX, ST_ILLEGAL: state_nxt = ST_DONE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: a function of registered state only, so there is no path from start or the operands.
  always_comb begin
    aluA       = 1'b0;
    aluB       = 1'b0;
    aluCin     = 1'b0;
    aluSel     = 2'b00;
    aluBinvert = 1'b0;
    aluLess    = 1'b0;
    bus.ready  = idle_like;
    bus.done   = (state == ST_DONE);
    case (state)
      ST_RUN: begin
        aluA       = a_sh[0];
        aluB       = b_sh[0];
        aluCin     = carry_q;
        aluBinvert = op_q[2];
        aluSel     = is_arith ? 2'b10 : {1'b0, op_q[0]};
      end
      ST_SLT_FIX: begin
        aluSel  = 2'b11;
        aluLess = sign_q ^ ovf_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      result_q    <= '0;
      cnt         <= '0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op_q        <= bus.op;
            a_sh        <= bus.opA;
            b_sh        <= bus.opB;
            cnt         <= '0;
            carry_q     <= bus.op[2];
            zero_q      <= 1'b0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= !op_legal;
            if (!op_legal) begin
              result_q <= '0;
            end
          end
        end
        ST_RUN: begin
          result_q <= result_shift;
          carry_q  <= aluCout;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          cnt      <= cnt + CNT_W'(1);
          if (last_bit) begin
            sign_q <= aluDataOut;
            if (is_arith) begin
              ovf_q <= carry_q ^ aluCout;
            end
            // SLT reports no carry. Its zero flag is settled in SLT_FIX.
            carry_out_q <= is_arith && !is_slt && aluCout;
            if (!is_slt) begin
              zero_q <= (result_shift == '0);
            end
          end
        end
        ST_SLT_FIX: begin
          result_q <= {{(WIDTH-1){1'b0}}, aluDataOut};
          zero_q   <= !aluDataOut;
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_out_q;
  assign bus.overflow = ovf_q;
  assign bus.err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
// ============================================================================
// Module   : tb_alu_serial_ctrl
// Purpose  : Self-checking bench for alu_serial_ctrl at WIDTH=8. It includes a
//            behavioural 1-bit slice model and a done-driven scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_serial_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic         e;
    int           lat;
  } vec_t;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic         e;
    int           lat;
    int           t0;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic aluA, aluB, aluCin, aluBinvert, aluLess, aluDataOut, aluCout;
  logic [1:0] aluSel;
  logic bx;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  sb_t  sb[$];
  vec_t tbl[14];

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .aluA       (aluA),
    .aluB       (aluB),
    .aluCin     (aluCin),
    .aluSel     (aluSel),
    .aluBinvert (aluBinvert),
    .aluLess    (aluLess),
    .aluDataOut (aluDataOut),
    .aluCout    (aluCout)
  );

  // Combinational 1-bit ALU slice.
  assign bx      = aluB ^ aluBinvert;
  assign aluCout = (aluA & bx) | (aluA & aluCin) | (bx & aluCin);
  always_comb begin
    case (aluSel)
      2'b00:   aluDataOut = aluA & bx;
      2'b01:   aluDataOut = aluA | bx;
      2'b10:   aluDataOut = aluA ^ bx ^ aluCin;
      default: aluDataOut = aluLess;
    endcase
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    chk({tag, "_outs"}, {bus.done, bus.result, bus.zero, bus.carry, bus.overflow, bus.err}, 32'd0);
    chk({tag, "_alu"}, {aluA, aluB, aluCin, aluSel, aluBinvert, aluLess}, 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
  endtask

  task automatic issue(input int id, input vec_t v, input int hold);
    sb_t e;
    wait_ready();
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.opA   = v.a;
    bus.opB   = v.b;
    e.id  = id;  e.res = v.res; e.z = v.z; e.c = v.c;
    e.v   = v.v; e.e   = v.e;   e.lat = v.lat; e.t0 = cyc;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    vec_t h;
    //          op      a      b      res    z     c     v     e     lat
    tbl[0]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 9};
    tbl[1]  = '{3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 9};
    tbl[2]  = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    tbl[3]  = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    tbl[4]  = '{3'b111, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    tbl[5]  = '{3'b111, 8'h02, 8'hFD, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10};
    tbl[6]  = '{3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 10};
    tbl[7]  = '{3'b011, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    tbl[8]  = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 9};
    tbl[9]  = '{3'b110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 9};
    tbl[10] = '{3'b110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    tbl[11] = '{3'b000, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9};
    tbl[12] = '{3'b100, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    tbl[13] = '{3'b010, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 9};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.opA   = '0;
    bus.opB   = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && bus.done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done got=1 exp=0");
          end else begin
            sb_t e;
            e = sb.pop_front();
            chk($sformatf("v%0d_result", e.id), {24'd0, bus.result}, {24'd0, e.res});
            chk($sformatf("v%0d_flags", e.id), {bus.zero, bus.carry, bus.overflow, bus.err},
                {e.z, e.c, e.v, e.e});
            chk($sformatf("v%0d_latency", e.id), cyc - e.t0, e.lat);
            chk($sformatf("v%0d_alu_idle", e.id),
                {aluA, aluB, aluCin, aluSel, aluBinvert, aluLess}, 32'd0);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table: each start lands in the previous op's DONE cycle.
    for (int i = 0; i < 14; i++) begin
      issue(i, tbl[i], 1);
    end
    drain();

    // start held high through RUN must be ignored.
    h = '{3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    issue(100, h, 5);
    drain();

    // Reset at RUN bit 4 abandons the op with no done.
    wait_ready();
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.opA   = 8'h03;
    bus.opB   = 8'h04;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_state("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    h = '{3'b010, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    issue(101, h, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
